// File: rtl/system_debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer.
// STABLE_CYCLES_DEFAULT is 10 ms of the 50 MHz system clock.
package system_debounce_pkg;

    localparam int unsigned CLK_HZ                = 32'd50_000_000;
    localparam int unsigned DEBOUNCE_MS           = 32'd10;
    localparam int unsigned STABLE_CYCLES_DEFAULT = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;

    // Number of clk cycles in a debounce window of 'ms' milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 32'd1000) * ms;
    endfunction

    // Smallest counter width that can hold the value max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 32'd2) ? 32'd1 : $clog2(max_count + 32'd1);
    endfunction

endpackage

// File: rtl/system_debounce_channel.sv
// One debouncer channel: two-flop synchroniser, stability counter,
// clean level flop and registered press/release pulses.
module system_debounce_channel
    import system_debounce_pkg::*;
#(
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic debounced_o,
    output logic press_o,
    output logic release_o
);

    // Count value reached on the last edge before a new level is accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;

    // Two-flop synchroniser bringing the asynchronous pin level into clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= level_i;
            s2_q <= s1_q;
        end
    end

    // Stability counter: any sample matching the current level restarts it;
    // the new level is accepted once it has persisted for STABLE_CYCLES edges.
    always_comb begin
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s2_q == deb_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == LAST_CNT) begin
            cnt_d   = {CNT_W{1'b0}};
            deb_d   = s2_q;
            press_d = s2_q;
            rel_d   = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter, clean level and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= {CNT_W{1'b0}};
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign debounced_o = deb_q;
    assign press_o     = press_q;
    assign release_o   = rel_q;

endmodule

// File: rtl/system_button_debouncer.sv
// Debounces WIDTH raw push-button pins into clean 1 = pressed levels for
// the PIO in_port, plus one-cycle press/release pulses per channel.
module system_button_debouncer
    import system_debounce_pkg::*;
#(
    parameter int WIDTH         = 5,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 500000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    // Reject counter thresholds that are too small or do not fit in CNT_W.
    if ((STABLE_CYCLES < 2) ||
        (64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_param
        $error("system_button_debouncer: STABLE_CYCLES must be in 2 .. 2**CNT_W-1");
    end

    // Normalised pin levels: 1 = pressed regardless of board polarity.
    logic [WIDTH-1:0] level_s;
    assign level_s = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        system_debounce_channel #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .level_i     (level_s[i]),
            .debounced_o (debounced[i]),
            .press_o     (press_pulse[i]),
            .release_o   (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_system_button_debouncer.sv
// Self-checking bench for system_button_debouncer (STABLE_CYCLES = 4).
// Reference model: the clean level flips on the edge where the last
// STABLE synchronised samples all differ from it and at least STABLE edges
// have passed since its previous flip.
module tb_system_button_debouncer;

    localparam int STABLE = 4;
    localparam int W      = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] btn_raw = 5'h1F;
    logic [W-1:0] debounced;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_deb;
    logic [W-1:0] m_prs;
    logic [W-1:0] m_rel;
    int           last_flip[W];

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] deb;
        logic [W-1:0] prs;
        logic [W-1:0] rel;
    } vec_t;
    vec_t tbl[18];

    system_button_debouncer #(
        .WIDTH         (W),
        .CNT_W         (20),
        .STABLE_CYCLES (STABLE),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .debounced     (debounced),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        m_deb = '0;
        m_prs = '0;
        m_rel = '0;
        for (int c = 0; c < W; c++) last_flip[c] = -1000;
    endtask

    // Called at a negedge: drive raw, advance one edge, update model, compare.
    task automatic step(input logic [W-1:0] raw);
        int k;
        btn_raw = raw;
        @(posedge clk);
        hist.push_back(~raw);
        k = hist.size() - 1;
        m_prs = '0;
        m_rel = '0;
        for (int c = 0; c < W; c++) begin
            bit ok;
            ok = ((k - last_flip[c]) >= STABLE);
            for (int j = k - STABLE + 1; j <= k; j++) begin
                logic [W-1:0] v;
                logic sv;
                if (j >= 2) begin
                    v  = hist[j-2];
                    sv = v[c];
                end else begin
                    sv = 1'b0;
                end
                if (sv == m_deb[c]) ok = 1'b0;
            end
            if (ok) begin
                m_deb[c]     = ~m_deb[c];
                last_flip[c] = k;
                if (m_deb[c]) m_prs[c] = 1'b1;
                else          m_rel[c] = 1'b1;
            end
        end
        #1;
        check("model_deb", debounced, m_deb);
        check("model_press", press_pulse, m_prs);
        check("model_release", release_pulse, m_rel);
        @(negedge clk);
    endtask

    // Called at a negedge: assert reset, check async clear, release at a negedge.
    task automatic apply_reset(input logic [W-1:0] raw);
        btn_raw = raw;
        reset_n = 1'b0;
        #1;
        check("rst_deb", debounced, 5'h00);
        check("rst_press", press_pulse, 5'h00);
        check("rst_release", release_pulse, 5'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_deb", debounced, 5'h00);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        // Press ch0 and hold, then bounce ch2 with ch0 still held.
        for (int i = 0; i < 5; i++) tbl[i] = '{5'h1E, 5'h00, 5'h00, 5'h00};
        tbl[5] = '{5'h1E, 5'h01, 5'h01, 5'h00};
        tbl[6] = '{5'h1E, 5'h01, 5'h00, 5'h00};
        tbl[7] = '{5'h1E, 5'h01, 5'h00, 5'h00};
        for (int i = 8; i < 11; i++) tbl[i] = '{5'h1A, 5'h01, 5'h00, 5'h00};
        tbl[11] = '{5'h1E, 5'h01, 5'h00, 5'h00};
        tbl[12] = '{5'h1A, 5'h01, 5'h00, 5'h00};
        tbl[13] = '{5'h1A, 5'h01, 5'h00, 5'h00};
        for (int i = 14; i < 18; i++) tbl[i] = '{5'h1E, 5'h01, 5'h00, 5'h00};

        model_clear();
        @(negedge clk);

        // Reset with all buttons released: no activity afterwards.
        apply_reset(5'h1F);
        for (int i = 0; i < 6; i++) step(5'h1F);
        check("idle_deb", debounced, 5'h00);

        // Table-driven press latency and bounce filtering.
        apply_reset(5'h1F);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].raw);
            check("tbl_deb", debounced, tbl[i].deb);
            check("tbl_press", press_pulse, tbl[i].prs);
            check("tbl_release", release_pulse, tbl[i].rel);
        end

        // Channel 1 release after a stable press.
        apply_reset(5'h1F);
        for (int i = 0; i < 8; i++) step(5'h1D);
        check("ch1_pressed", debounced, 5'h02);
        for (int i = 0; i < 5; i++) step(5'h1F);
        check("ch1_still_held", debounced, 5'h02);
        step(5'h1F);
        check("ch1_released", debounced, 5'h00);
        check("ch1_rel_pulse", release_pulse, 5'h02);
        step(5'h1F);
        check("ch1_rel_one_cycle", release_pulse, 5'h00);

        // Channels 4 and 3 pressed together.
        apply_reset(5'h1F);
        for (int i = 0; i < 5; i++) step(5'h07);
        check("dual_before", debounced, 5'h00);
        step(5'h07);
        check("dual_deb", debounced, 5'h18);
        check("dual_press", press_pulse, 5'h18);
        step(5'h07);
        check("dual_press_end", press_pulse, 5'h00);

        // Reset one edge before acceptance, button held through reset.
        apply_reset(5'h1F);
        for (int i = 0; i < 5; i++) step(5'h1E);
        apply_reset(5'h1E);
        for (int i = 0; i < 5; i++) step(5'h1E);
        check("rearm_before", debounced, 5'h00);
        step(5'h1E);
        check("rearm_deb", debounced, 5'h01);
        check("rearm_press", press_pulse, 5'h01);

        // Randomised held levels of varying length against the model.
        apply_reset(5'h1F);
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] r;
            int hold;
            r    = W'($urandom);
            hold = int'($urandom_range(1, 7));
            if (n == 200) apply_reset(r);
            for (int h = 0; h < hold; h++) step(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/system_button_debouncer.md
Name: system_button_debouncer

Overview:
- Conditions raw mechanical push-button/switch inputs from board pins before they reach the SET PIO input (`in_port`, 5 bits), whose edge-capture logic would otherwise latch every contact bounce as an interrupt.
- Per channel: two-flop synchronisation into `clk`, then a stability counter, then a clean debounced level.
- Also emits one-cycle press/release pulses for local consumers.
- Instantiated in the system top between the pins and the PIO `in_port`.

Parameters:
- WIDTH, 5, number of button channels; must match the PIO `in_port` width.
- CNT_W, 20, stability counter width.
- STABLE_CYCLES, 500000, consecutive cycles a synchronised input must differ from the debounced level before it is accepted (10 ms at 50 MHz); legal range 2 .. 2^CNT_W-1.
- ACTIVE_LOW, 1, 1 = pins are low when pressed; the input is inverted so outputs are always 1 = pressed.

Ports:
- clk  in  1  system clock; sole clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- btn_raw  in  WIDTH  asynchronous raw pin levels.
- debounced  out  WIDTH  clean level, 1 = pressed; drives PIO `in_port`.
- press_pulse  out  WIDTH  one-cycle high when `debounced[i]` goes 0->1.
- release_pulse  out  WIDTH  one-cycle high when `debounced[i]` goes 1->0.

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-low (`reset_n`); all flops reset on negedge `reset_n`, no synchronous reset.
- Input normalisation: `n = ACTIVE_LOW ? ~btn_raw : btn_raw`.
- Synchroniser: `s1 <= n`, `s2 <= s1`.
- Reset values: `s1`, `s2`, counters, `debounced`, `press_pulse` and `release_pulse` all 0. Since `s1`/`s2` reset to 0 (released), no spurious edge appears after reset.
- Per channel i, on each `clk` edge:
  - if `s2[i] == debounced[i]`: `cnt[i] <= 0` (any bounce back restarts the count);
  - else if `cnt[i] == STABLE_CYCLES-1`: `debounced[i] <= s2[i]`, `cnt[i] <= 0`;
  - else: `cnt[i] <= cnt[i]+1`.
- Latency: if `btn_raw[i]` changes before edge 0 and then holds, `debounced[i]` changes at edge STABLE_CYCLES+1.
- Filtering: any excursion of `s2[i]` shorter than STABLE_CYCLES cycles produces no output change.
- Pulses: registered, asserted on the same edge that updates `debounced`.
  - `press_pulse[i]` = 1 for exactly one cycle when `debounced[i]` goes 0->1.
  - `release_pulse[i]` = 1 for exactly one cycle when `debounced[i]` goes 1->0.
  - Both are 0 in every other cycle; never both high in one cycle.
- Channel independence: each channel is fully independent; simultaneous transitions on several channels are each processed in the same cycles.
- Counter bound: the counter never exceeds STABLE_CYCLES-1, so no wrap-around.
- Reset mid-count: clears the count and forces `debounced` to 0 with no pulse. A button held through reset is re-accepted STABLE_CYCLES+1 edges after reset release, with `press_pulse`.
- Parameter check: elaboration-time error if STABLE_CYCLES < 2 or STABLE_CYCLES > 2^CNT_W-1.

Decomposition:
- Shared package `system_debounce_pkg`:
  - default STABLE_CYCLES constant;
  - CNT_W derivation function (clog2);
  - CLK_HZ constant used to compute STABLE_CYCLES from milliseconds.
- One natural sub-module, `system_debounce_channel` (single bit: synchroniser, counter, level and pulse flops), instantiated WIDTH times by a generate loop in the top.

Test Plan (STABLE_CYCLES=4, WIDTH=5, ACTIVE_LOW=1):
- Reset held, `btn_raw=5'h1F`, then release -> `debounced=0`, no pulses, for all cycles with inputs constant.
- `btn_raw[0]` 1->0 before edge 0 and held -> `debounced[0]` = 1 at edge 5, `press_pulse[0]` high only in the cycle after edge 5.
- `btn_raw[2]` bounces low 3 cycles, high 1 cycle, low 2 cycles, then high -> `debounced[2]` stays 0, no pulses.
- Channel 1 pressed and stable, then `btn_raw[1]` returns high and holds -> `debounced[1]` falls at edge 5 after the change, `release_pulse[1]` one cycle only.
- `btn_raw[4:3]` pressed in the same cycle -> `debounced[4:3]` = 2'b11 on the same edge, both press pulses coincide, other bits 0.
- Channel 0 with `cnt[0]=3` (one edge before acceptance), assert `reset_n` low -> outputs 0 immediately; hold the button and release reset -> `debounced[0]` = 1 at edge 5 after release.
